// File: rtl/mapeador_pkg.sv
// Shared types for the occupancy-grid mapper: cell states, headings, FSM states.
package mapeador_pkg;

  // Two-bit cell encoding as seen on leituraCelula
  typedef enum logic [1:0] {
    DESCONHECIDO = 2'b00,
    LIVRE        = 2'b01,
    OCUPADO      = 2'b10
  } celula_t;

  // Robot heading: 0 = +Y, 1 = +X, 2 = -Y, 3 = -X
  typedef enum logic [1:0] {
    NORTE = 2'd0,
    LESTE = 2'd1,
    SUL   = 2'd2,
    OESTE = 2'd3
  } direcao_t;

  // Controller states; PROXIMO is evaluated inside the last RAIO cycle
  typedef enum logic [2:0] {
    IDLE,
    CAPTURA,
    RAIO,
    PROXIMO,
    LIMPEZA
  } estado_t;

  // Index of the last ray (frente = 0, direita = 1, esquerda = 2)
  localparam logic [1:0] ULTIMO_RAIO = 2'd2;

  // Heading of a ray relative to the robot: frente +0, direita +1, esquerda +3 (mod 4)
  function automatic direcao_t direcaoRaio(input direcao_t base, input logic [1:0] raio);
    logic [1:0] offset;
    logic [1:0] soma;
    case (raio)
      2'd0:    offset = 2'd0;
      2'd1:    offset = 2'd1;
      default: offset = 2'd3;
    endcase
    soma = base + offset;
    return direcao_t'(soma);
  endfunction

endpackage

// File: rtl/mapeador_grade_passo_raio.sv
// passo_raio: one step along a ray plus in-grid tests for the next two cells.
module passo_raio
  import mapeador_pkg::*;
#(
  parameter int TamanhoMalha = 20,
  parameter int W            = $clog2(TamanhoMalha)
) (
  input  logic signed [W:0] xAtual_i,
  input  logic signed [W:0] yAtual_i,
  input  direcao_t          direcao_i,
  output logic signed [W:0] xProx_o,
  output logic signed [W:0] yProx_o,
  output logic              proxDentro_o,
  output logic              seguinteDentro_o
);

  // Grid side as a signed coordinate, one bit wider than a cell index
  localparam logic signed [W:0] LADO     = (W+1)'(TamanhoMalha);
  localparam logic signed [W:0] UM       = {{W{1'b0}}, 1'b1};
  localparam logic signed [W:0] MENOS_UM = '1;
  localparam logic signed [W:0] ZERO     = '0;

  logic signed [W:0] dx;
  logic signed [W:0] dy;
  logic signed [W:0] xSeg;
  logic signed [W:0] ySeg;

  // Unit step for the heading, then the cell one step and two steps ahead
  always_comb begin
    dx = ZERO;
    dy = ZERO;
    case (direcao_i)
      NORTE:   dy = UM;
      LESTE:   dx = UM;
      SUL:     dy = MENOS_UM;
      default: dx = MENOS_UM;
    endcase
    xProx_o = xAtual_i + dx;
    yProx_o = yAtual_i + dy;
    xSeg    = xProx_o + dx;
    ySeg    = yProx_o + dy;
  end

  // A coordinate is inside when it is non-negative and below the grid side
  always_comb begin
    proxDentro_o     = !xProx_o[W] && !yProx_o[W] && (xProx_o < LADO) && (yProx_o < LADO);
    seguinteDentro_o = !xSeg[W] && !ySeg[W] && (xSeg < LADO) && (ySeg < LADO);
  end

endmodule

// File: rtl/mapeador_grade.sv
// mapeador_grade: occupancy grid updated by three echo rays per accepted request.
module mapeador_grade
  import mapeador_pkg::*;
#(
  parameter int TamanhoMalha     = 20,
  parameter int tamanhoDistancia = 8,
  parameter int DistanciaMaxima  = 15,
  parameter int LiberarOcupada   = 0,
  localparam int W               = $clog2(TamanhoMalha)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        novoDado,
  output logic                        operacaoFinalizada,
  input  logic [W-1:0]                posicaoX,
  input  logic [W-1:0]                posicaoY,
  input  logic [1:0]                  direcao,
  input  logic [tamanhoDistancia-1:0] distanciaFrente,
  input  logic [tamanhoDistancia-1:0] distanciaDireita,
  input  logic [tamanhoDistancia-1:0] distanciaEsquerda,
  input  logic                        limpar,
  input  logic [W-1:0]                leituraX,
  input  logic [W-1:0]                leituraY,
  output logic [1:0]                  leituraCelula,
  output logic                        concluido,
  output logic                        erroPosicao
);

  localparam logic [W:0]                  LADO_U       = (W+1)'(TamanhoMalha);
  localparam logic [W-1:0]                ULTIMA_LINHA = W'(TamanhoMalha - 1);
  localparam logic [tamanhoDistancia-1:0] DMAX         = tamanhoDistancia'(DistanciaMaxima);
  localparam logic [tamanhoDistancia-1:0] PASSO_UM     = {{(tamanhoDistancia-1){1'b0}}, 1'b1};

  // Controller registers
  estado_t                     estado_q, estado_d;
  logic [W-1:0]                posX_q, posX_d;
  logic [W-1:0]                posY_q, posY_d;
  direcao_t                    dir_q, dir_d;
  logic [tamanhoDistancia-1:0] distF_q, distF_d;
  logic [tamanhoDistancia-1:0] distD_q, distD_d;
  logic [tamanhoDistancia-1:0] distE_q, distE_d;
  logic [1:0]                  raio_q, raio_d;
  logic [tamanhoDistancia-1:0] passo_q, passo_d;
  logic signed [W:0]           curX_q, curX_d;
  logic signed [W:0]           curY_q, curY_d;
  logic [W-1:0]                linha_q, linha_d;
  logic                        concluido_q, concluido_d;
  logic                        erro_q, erro_d;
  celula_t                     leitura_q;

  // Cell storage, indexed [y][x] so that a whole row can be cleared at once
  celula_t grade_q [TamanhoMalha][TamanhoMalha];

  // Current-ray helpers
  direcao_t                    dirAtual;
  logic [tamanhoDistancia-1:0] distAtual;
  logic                        comEco;
  logic [tamanhoDistancia-1:0] limite;
  logic signed [W:0]           xProx;
  logic signed [W:0]           yProx;
  logic                        proxDentro;
  logic                        seguinteDentro;
  logic                        posValida;
  logic                        leituraValida;
  logic                        fimRaio;

  // Write port
  logic         escreve;
  logic [W-1:0] wX;
  logic [W-1:0] wY;
  celula_t      wVal;
  logic         aplica;
  logic         limpaLinha;

  passo_raio #(
    .TamanhoMalha(TamanhoMalha),
    .W           (W)
  ) u_passo (
    .xAtual_i        (curX_q),
    .yAtual_i        (curY_q),
    .direcao_i       (dirAtual),
    .xProx_o         (xProx),
    .yProx_o         (yProx),
    .proxDentro_o    (proxDentro),
    .seguinteDentro_o(seguinteDentro)
  );

  // Select the active ray's heading and distance; clamp the walk length to the echo range
  always_comb begin
    dirAtual = direcaoRaio(dir_q, raio_q);
    case (raio_q)
      2'd0:    distAtual = distF_q;
      2'd1:    distAtual = distD_q;
      default: distAtual = distE_q;
    endcase
    comEco = (distAtual <= DMAX);
    limite = comEco ? distAtual : DMAX;
  end

  // Range checks for the request position and the read address
  always_comb begin
    posValida     = ({1'b0, posicaoX} < LADO_U) && ({1'b0, posicaoY} < LADO_U);
    leituraValida = ({1'b0, leituraX} < LADO_U) && ({1'b0, leituraY} < LADO_U);
  end

  // Next-state and write-port decode; the hop to the next ray happens on the ray's last cycle
  always_comb begin
    estado_d    = estado_q;
    posX_d      = posX_q;
    posY_d      = posY_q;
    dir_d       = dir_q;
    distF_d     = distF_q;
    distD_d     = distD_q;
    distE_d     = distE_q;
    raio_d      = raio_q;
    passo_d     = passo_q;
    curX_d      = curX_q;
    curY_d      = curY_q;
    linha_d     = linha_q;
    concluido_d = 1'b0;
    erro_d      = 1'b0;
    escreve     = 1'b0;
    wX          = '0;
    wY          = '0;
    wVal        = DESCONHECIDO;
    limpaLinha  = 1'b0;
    fimRaio     = 1'b0;

    case (estado_q)
      IDLE: begin
        if (limpar) begin
          estado_d = LIMPEZA;
          linha_d  = '0;
        end else if (novoDado) begin
          if (posValida) begin
            posX_d   = posicaoX;
            posY_d   = posicaoY;
            dir_d    = direcao_t'(direcao);
            distF_d  = distanciaFrente;
            distD_d  = distanciaDireita;
            distE_d  = distanciaEsquerda;
            raio_d   = 2'd0;
            passo_d  = PASSO_UM;
            curX_d   = $signed({1'b0, posicaoX});
            curY_d   = $signed({1'b0, posicaoY});
            escreve  = 1'b1;
            wX       = posicaoX;
            wY       = posicaoY;
            wVal     = LIVRE;
            estado_d = CAPTURA;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      CAPTURA: begin
        estado_d = RAIO;
      end

      RAIO: begin
        if ((distAtual == '0) || !proxDentro) begin
          fimRaio = 1'b1;
        end else begin
          escreve = 1'b1;
          wX      = xProx[W-1:0];
          wY      = yProx[W-1:0];
          wVal    = (comEco && (passo_q == distAtual)) ? OCUPADO : LIVRE;
          if ((passo_q == limite) || !seguinteDentro) begin
            fimRaio = 1'b1;
          end else begin
            passo_d = passo_q + PASSO_UM;
            curX_d  = xProx;
            curY_d  = yProx;
          end
        end
        if (fimRaio) begin
          if (raio_q == ULTIMO_RAIO) begin
            estado_d    = IDLE;
            concluido_d = 1'b1;
          end else begin
            raio_d  = raio_q + 2'd1;
            passo_d = PASSO_UM;
            curX_d  = $signed({1'b0, posX_q});
            curY_d  = $signed({1'b0, posY_q});
          end
        end
      end

      LIMPEZA: begin
        limpaLinha = 1'b1;
        if (linha_q == ULTIMA_LINHA) begin
          estado_d    = IDLE;
          concluido_d = 1'b1;
        end else begin
          linha_d = linha_q + 1'b1;
        end
      end

      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // Free writes never erase an obstacle unless the map is allowed to release occupied cells
  always_comb begin
    aplica = escreve;
    if ((wVal == LIVRE) && (LiberarOcupada == 0) && (grade_q[wY][wX] == OCUPADO)) begin
      aplica = 1'b0;
    end
  end

  // Controller state register
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= IDLE;
      posX_q      <= '0;
      posY_q      <= '0;
      dir_q       <= NORTE;
      distF_q     <= '0;
      distD_q     <= '0;
      distE_q     <= '0;
      raio_q      <= '0;
      passo_q     <= '0;
      curX_q      <= '0;
      curY_q      <= '0;
      linha_q     <= '0;
      concluido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      posX_q      <= posX_d;
      posY_q      <= posY_d;
      dir_q       <= dir_d;
      distF_q     <= distF_d;
      distD_q     <= distD_d;
      distE_q     <= distE_d;
      raio_q      <= raio_d;
      passo_q     <= passo_d;
      curX_q      <= curX_d;
      curY_q      <= curY_d;
      linha_q     <= linha_d;
      concluido_q <= concluido_d;
      erro_q      <= erro_d;
    end
  end

  // Grid storage: full wipe on reset, one row per cycle while clearing, else one cell write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int y = 0; y < TamanhoMalha; y++) begin
        for (int x = 0; x < TamanhoMalha; x++) begin
          grade_q[y][x] <= DESCONHECIDO;
        end
      end
    end else if (limpaLinha) begin
      for (int x = 0; x < TamanhoMalha; x++) begin
        grade_q[linha_q][x] <= DESCONHECIDO;
      end
    end else if (aplica) begin
      grade_q[wY][wX] <= wVal;
    end
  end

  // Registered read port; sees the value before any write landing on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      leitura_q <= DESCONHECIDO;
    end else if (leituraValida) begin
      leitura_q <= grade_q[leituraY][leituraX];
    end else begin
      leitura_q <= DESCONHECIDO;
    end
  end

  assign operacaoFinalizada = (estado_q == IDLE);
  assign concluido          = concluido_q;
  assign erroPosicao        = erro_q;
  assign leituraCelula      = leitura_q;

endmodule

// File: tb/tb_mapeador_grade.sv
// Self-checking bench for mapeador_grade against a ray-walking reference model.
module tb_mapeador_grade;

  localparam int LADO    = 20;
  localparam int TAM_D   = 8;
  localparam int DMAX    = 15;
  localparam int LIBERAR = 0;
  localparam int W       = $clog2(LADO);

  logic             clock;
  logic             reset;
  logic             novoDado;
  logic             operacaoFinalizada;
  logic [W-1:0]     posicaoX;
  logic [W-1:0]     posicaoY;
  logic [1:0]       direcao;
  logic [TAM_D-1:0] distanciaFrente;
  logic [TAM_D-1:0] distanciaDireita;
  logic [TAM_D-1:0] distanciaEsquerda;
  logic             limpar;
  logic [W-1:0]     leituraX;
  logic [W-1:0]     leituraY;
  logic [1:0]       leituraCelula;
  logic             concluido;
  logic             erroPosicao;

  int checks = 0;
  int errors = 0;

  // Reference grid, indexed [x][y]; 0 unknown, 1 free, 2 occupied
  int grade [LADO][LADO];

  mapeador_grade #(
    .TamanhoMalha    (LADO),
    .tamanhoDistancia(TAM_D),
    .DistanciaMaxima (DMAX),
    .LiberarOcupada  (LIBERAR)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .novoDado          (novoDado),
    .operacaoFinalizada(operacaoFinalizada),
    .posicaoX          (posicaoX),
    .posicaoY          (posicaoY),
    .direcao           (direcao),
    .distanciaFrente   (distanciaFrente),
    .distanciaDireita  (distanciaDireita),
    .distanciaEsquerda (distanciaEsquerda),
    .limpar            (limpar),
    .leituraX          (leituraX),
    .leituraY          (leituraY),
    .leituraCelula     (leituraCelula),
    .concluido         (concluido),
    .erroPosicao       (erroPosicao)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observado=%0d esperado=%0d", tag, observed, expected);
    end
  endtask

  function automatic void modelClear();
    for (int x = 0; x < LADO; x++)
      for (int y = 0; y < LADO; y++)
        grade[x][y] = 0;
  endfunction

  function automatic void modelWrite(input int x, input int y, input int v);
    if (!(v == 1 && LIBERAR == 0 && grade[x][y] == 2))
      grade[x][y] = v;
  endfunction

  // Walks the three rays on the reference grid and returns the expected cycle count
  function automatic int modelRequest(input int px, input int py, input int dir,
                                      input int f, input int r, input int l);
    int dxTab [4] = '{0, 1, 0, -1};
    int dyTab [4] = '{1, 0, -1, 0};
    int offs  [3] = '{0, 1, 3};
    int dists [3];
    int lat;
    dists[0] = f;
    dists[1] = r;
    dists[2] = l;
    lat = 1;
    modelWrite(px, py, 1);
    for (int i = 0; i < 3; i++) begin
      int h, d, lim, cells, x, y;
      h     = (dir + offs[i]) % 4;
      d     = dists[i];
      lim   = (d > DMAX) ? DMAX : d;
      cells = 0;
      for (int k = 1; k <= lim; k++) begin
        x = px + k * dxTab[h];
        y = py + k * dyTab[h];
        if (x < 0 || y < 0 || x >= LADO || y >= LADO) break;
        modelWrite(x, y, (k == d) ? 2 : 1);
        cells++;
      end
      lat += (cells > 0) ? cells : 1;
    end
    return lat;
  endfunction

  task automatic readCell(input int x, input int y, output int valor);
    leituraX = W'(x);
    leituraY = W'(y);
    @(posedge clock); #1;
    valor = int'(leituraCelula);
  endtask

  task automatic verifyGrid(input string tag);
    int v;
    for (int y = 0; y < LADO; y++)
      for (int x = 0; x < LADO; x++) begin
        readCell(x, y, v);
        checkOutput($sformatf("%s(%0d,%0d)", tag, x, y), v, grade[x][y]);
      end
  endtask

  // Issues one request from IDLE, waits (bounded) for completion and checks the handshake
  task automatic applyStimulus(input int px, input int py, input int dir,
                               input int f, input int r, input int l, output int medida);
    bit valida;
    int antigo, expLat, cnt;
    valida            = (px < LADO) && (py < LADO);
    posicaoX          = W'(px);
    posicaoY          = W'(py);
    direcao           = 2'(dir);
    distanciaFrente   = TAM_D'(f);
    distanciaDireita  = TAM_D'(r);
    distanciaEsquerda = TAM_D'(l);
    antigo            = 0;
    medida            = 0;
    if (valida) begin
      leituraX = W'(px);
      leituraY = W'(py);
      antigo   = grade[px][py];
    end
    novoDado = 1'b1;
    @(posedge clock); #1;
    novoDado = 1'b0;
    if (!valida) begin
      checkOutput("rej_erro", int'(erroPosicao), 1);
      checkOutput("rej_pronto", int'(operacaoFinalizada), 1);
      @(posedge clock); #1;
      checkOutput("rej_erro_fim", int'(erroPosicao), 0);
    end else begin
      checkOutput("leitura_pre_escrita", int'(leituraCelula), antigo);
      checkOutput("ocupado_apos_aceite", int'(operacaoFinalizada), 0);
      checkOutput("erro_ausente", int'(erroPosicao), 0);
      expLat = modelRequest(px, py, dir, f, r, l);
      cnt = 0;
      while (!operacaoFinalizada && cnt < 200) begin
        @(posedge clock); #1;
        cnt++;
      end
      medida = cnt;
      checkOutput("latencia", cnt, expLat);
      checkOutput("concluido_pulso", int'(concluido), 1);
      @(posedge clock); #1;
      checkOutput("concluido_fim", int'(concluido), 0);
    end
  endtask

  initial begin
    int lat, v, cnt;
    reset = 1'b1; novoDado = 1'b0; limpar = 1'b0;
    posicaoX = '0; posicaoY = '0; direcao = '0;
    distanciaFrente = '0; distanciaDireita = '0; distanciaEsquerda = '0;
    leituraX = '0; leituraY = '0;
    modelClear();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_pronto", int'(operacaoFinalizada), 1);
    checkOutput("reset_concluido", int'(concluido), 0);
    checkOutput("reset_erro", int'(erroPosicao), 0);
    checkOutput("reset_leitura", int'(leituraCelula), 0);
    verifyGrid("reset");

    $display("[TB] basic mapping");
    applyStimulus(5, 5, 1, 3, 0, 2, lat);
    checkOutput("basico_latencia7", lat, 7);
    readCell(8, 5, v); checkOutput("basico_8_5", v, 2);
    readCell(5, 7, v); checkOutput("basico_5_7", v, 2);
    readCell(5, 4, v); checkOutput("basico_5_4", v, 0);
    verifyGrid("basico");

    $display("[TB] edge clip");
    applyStimulus(18, 0, 1, 5, 3, 0, lat);
    checkOutput("borda_latencia", lat, 4);
    readCell(19, 0, v); checkOutput("borda_19_0", v, 1);
    readCell(0, 0, v);  checkOutput("borda_sem_wrap", v, 0);
    verifyGrid("borda");

    $display("[TB] no echo and occupied protection");
    applyStimulus(0, 0, 0, 255, 0, 0, lat);
    checkOutput("sem_eco_latencia", lat, 18);
    readCell(0, 15, v); checkOutput("sem_eco_0_15", v, 1);
    readCell(0, 16, v); checkOutput("sem_eco_0_16", v, 0);
    applyStimulus(0, 0, 0, 3, 0, 0, lat);
    applyStimulus(0, 0, 0, 255, 0, 0, lat);
    readCell(0, 3, v); checkOutput("ocupado_mantido", v, 2);
    verifyGrid("sem_eco");

    $display("[TB] reject");
    applyStimulus(20, 4, 1, 3, 3, 3, lat);
    verifyGrid("rejeicao");

    $display("[TB] clear wins over request");
    posicaoX = W'(3); posicaoY = W'(3);
    limpar = 1'b1; novoDado = 1'b1;
    @(posedge clock); #1;
    limpar = 1'b0; novoDado = 1'b0;
    checkOutput("limpeza_ocupado", int'(operacaoFinalizada), 0);
    checkOutput("limpeza_sem_erro", int'(erroPosicao), 0);
    cnt = 0;
    while (!concluido && cnt < 100) begin
      @(posedge clock); #1;
      cnt++;
      if (!concluido) checkOutput("limpeza_ainda_ocupado", int'(operacaoFinalizada), 0);
    end
    checkOutput("limpeza_ciclos", cnt, 20);
    checkOutput("limpeza_pronto", int'(operacaoFinalizada), 1);
    modelClear();
    verifyGrid("limpeza");

    $display("[TB] reset abort");
    posicaoX = W'(10); posicaoY = W'(10); direcao = 2'd0;
    distanciaFrente = TAM_D'(10); distanciaDireita = TAM_D'(10); distanciaEsquerda = TAM_D'(10);
    novoDado = 1'b1;
    @(posedge clock); #1;
    novoDado = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("aborto_pronto", int'(operacaoFinalizada), 1);
    checkOutput("aborto_concluido", int'(concluido), 0);
    checkOutput("aborto_leitura", int'(leituraCelula), 0);
    reset = 1'b0;
    modelClear();
    verifyGrid("aborto");

    $display("[TB] randomized requests");
    for (int i = 0; i < 16; i++) begin
      int px, py, dir, d [3];
      px  = $urandom_range(0, LADO + 1);
      py  = $urandom_range(0, LADO + 1);
      dir = $urandom_range(0, 3);
      for (int j = 0; j < 3; j++)
        d[j] = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, DMAX + 3);
      applyStimulus(px, py, dir, d[0], d[1], d[2], lat);
    end
    verifyGrid("aleatorio");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
